// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   OP_ADD/SUB: encoding of the op input
//   cnt_width : bit-counter width for a given operand width (minimum 1)
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Counter must index 0..w-1; a 2-bit operand still needs one counter bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder used as the single bit-slice of the serial adder.
//   a, b : addend bits
//   c    : carry in
//   cy   : carry out
//   sum  : sum bit
module serial_adder_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic cy,
   output logic sum
);

   assign sum = a ^ b ^ c;
   assign cy  = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: operands are latched on an accepted
// start and pushed LSB-first through one full adder, one bit per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start, op  : request and operation (0 add, 1 subtract a - b), sampled when not busy
//   cin        : carry-in for add, ignored for subtract
//   a, b       : WIDTH-bit operands, sampled with start
//   busy       : high while bits are being processed (RUN)
//   done       : one-cycle pulse when sum/cout/ovf are valid
//   sum        : result, held until the next completion
//   cout       : unsigned carry out (subtract: 1 = no borrow)
//   ovf        : two's-complement overflow
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_r;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] acc_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             fa_sum_s;
   logic             fa_cy_s;
   logic             accept_s;
   logic             last_s;

   serial_adder_ctrl_fa u_fa (
      .a   (sa_r[0]),
      .b   (sb_r[0]),
      .c   (carry_r),
      .cy  (fa_cy_s),
      .sum (fa_sum_s)
   );

   // State register; busy/done are registered decodes of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         busy_r  <= (state_nxt == RUN);
         done_r  <= (state_nxt == DONE);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt = RUN;
            else       state_nxt = IDLE;
         end
         RUN: begin
            if (last_s) state_nxt = DONE;
            else        state_nxt = RUN;
         end
         DONE: begin
            if (start) state_nxt = RUN;
            else       state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control strobes: accept a request (IDLE or back-to-back from DONE) and flag the final bit.
   always_comb begin
      accept_s = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         IDLE:    accept_s = start;
         RUN:     last_s   = (cnt_r == LAST_CNT);
         DONE:    accept_s = start;
         default: begin
            accept_s = 1'b0;
            last_s   = 1'b0;
         end
      endcase
   end

   // Operand shift registers, carry flop, bit counter and sum accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_r    <= {WIDTH{1'b0}};
         sb_r    <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         // Subtract is a + ~b + 1: invert b and force the initial carry.
         sa_r    <= a;
         sb_r    <= (op == OP_SUB) ? ~b : b;
         carry_r <= (op == OP_SUB) ? 1'b1 : cin;
         acc_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == RUN) begin
         sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
         sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
         acc_r   <= {fa_sum_s, acc_r[WIDTH-1:1]};
         carry_r <= fa_cy_s;
         // Hold on the final bit so a power-of-two WIDTH never wraps.
         cnt_r   <= last_s ? cnt_r : cnt_r + CNT_W'(1);
      end else begin
         sa_r    <= sa_r;
         sb_r    <= sb_r;
         acc_r   <= acc_r;
         carry_r <= carry_r;
         cnt_r   <= cnt_r;
      end
   end

   // Result registers, loaded only on the edge that enters DONE.
   // On that edge carry_r is the carry into the MSB and fa_cy_s the carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r  <= {WIDTH{1'b0}};
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (last_s) begin
         sum_r  <= {fa_sum_s, acc_r[WIDTH-1:1]};
         cout_r <= fa_cy_s;
         ovf_r  <= carry_r ^ fa_cy_s;
      end else begin
         sum_r  <= sum_r;
         cout_r <= cout_r;
         ovf_r  <= ovf_r;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_adder_ctrl;
   import serial_adder_ctrl_pkg::*;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op    = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = 8'h00;
   logic [W-1:0] b     = 8'h00;
   wire          busy;
   wire          done;
   wire  [W-1:0] sum;
   wire          cout;
   wire          ovf;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic ci);
      exp_t         m;
      logic [W-1:0] yy;
      logic         cc;
      logic [W:0]   t;
      yy  = o ? ~y : y;
      cc  = o ? 1'b1 : ci;
      t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
      m.s = t[W-1:0];
      m.c = t[W];
      m.v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci);
      op    = o;
      a     = x;
      b     = y;
      cin   = ci;
      start = 1'b1;
      sb_q.push_back(model(o, x, y, ci));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic compare_result(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
         e        = sb_q.pop_front();
         last_exp = e;
         check({tag, "_sum"},  sum,  e.s);
         check({tag, "_cout"}, cout, e.c);
         check({tag, "_ovf"},  ovf,  e.v);
      end
   endtask

   task automatic do_op(input string tag, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci);
      int n;
      drive(o, x, y, ci);
      step();
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      wait_done(n);
      check({tag, "_latency"}, n, W);
      compare_result(tag);
      step();
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      int n;
      int dcnt;

      // Reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum",  sum,  0);
      check("rst_cout", cout, 0);
      check("rst_ovf",  ovf,  0);
      #11 rst_n = 1'b1;
      step();
      step();

      // Directed arithmetic cases
      do_op("add_a5_3c",  OP_ADD, 8'hA5, 8'h3C, 1'b0);
      do_op("add_wrap",   OP_ADD, 8'hFF, 8'h00, 1'b1);
      do_op("sub_borrow", OP_SUB, 8'h10, 8'h20, 1'b1);
      do_op("sub_ok",     OP_SUB, 8'h20, 8'h10, 1'b0);
      do_op("add_ovf",    OP_ADD, 8'h7F, 8'h01, 1'b0);
      do_op("sub_ovf",    OP_SUB, 8'h80, 8'h01, 1'b0);

      // Outputs hold through IDLE
      repeat (5) step();
      check("hold_sum",  sum,  last_exp.s);
      check("hold_cout", cout, last_exp.c);
      check("hold_ovf",  ovf,  last_exp.v);
      check("hold_busy", busy, 0);

      // start during RUN is ignored
      drive(OP_ADD, 8'h12, 8'h34, 1'b0);
      step();
      start = 1'b0;
      step();
      step();
      op    = OP_SUB;
      a     = 8'hFF;
      b     = 8'h01;
      start = 1'b1;
      step();
      start = 1'b0;
      check("ign_hold_sum", sum, last_exp.s);
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            dcnt++;
            compare_result("ignored_start");
         end
         step();
      end
      check("ign_done_count", dcnt, 1);

      // Back-to-back acceptance in the DONE cycle
      drive(OP_ADD, 8'h55, 8'h0F, 1'b1);
      step();
      start = 1'b0;
      wait_done(n);
      drive(OP_SUB, 8'h03, 8'h09, 1'b0);
      compare_result("b2b_first");
      step();
      start = 1'b0;
      check("b2b_busy", busy, 1);
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("b2b_gap", n, W + 1);
      compare_result("b2b_second");
      step();

      // Asynchronous reset in the 4th RUN cycle
      drive(OP_ADD, 8'h11, 8'h22, 1'b0);
      step();
      start = 1'b0;
      step();
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_sum",  sum,  0);
      check("arst_cout", cout, 0);
      check("arst_ovf",  ovf,  0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (done === 1'b1) dcnt++;
      end
      check("arst_no_done", dcnt, 0);
      do_op("after_rst", OP_ADD, 8'hC3, 8'h5A, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
